lfsr_pattern_gen: RTL and testbench



---
 rtl/lfsr_pkg.sv | 13 +
 rtl/lfsr_step.sv | 23 ++
 rtl/lfsr_pattern_gen.sv | 125 ++++++++++++
 tb/tb_lfsr_pattern_gen.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and maximal-length tap constants for the LFSR pattern generator.
package lfsr_pkg;

  typedef enum logic {LFSR_FIB_XNOR, LFSR_GAL_XOR} lfsr_mode_t;

  typedef enum logic {IDLE, RUN} fsm_state_t;

  localparam logic [7:0]  LFSR_POLY_8  = 8'hB8;
  localparam logic [15:0] LFSR_POLY_16 = 16'hB400;
  localparam logic [31:0] LFSR_POLY_32 = 32'h8020_0003;
  localparam logic [63:0] LFSR_POLY_64 = 64'hD800_0000_0000_0000;

endpackage

// File: rtl/lfsr_step.sv
// Combinational single LFSR step: Fibonacci XNOR shift-left or Galois XOR shift-right.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter logic [63:0] POLY  = LFSR_POLY_64,
  parameter int unsigned MODE  = 0
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);

  localparam logic [WIDTH-1:0] TAPS = POLY[WIDTH-1:0];

  generate
    if (MODE == 32'(LFSR_GAL_XOR)) begin : g_galois
      assign nxt = (cur >> 1) ^ (cur[0] ? TAPS : {WIDTH{1'b0}});
    end else begin : g_fib
      assign nxt = {cur[WIDTH-2:0], ~^(cur & TAPS)};
    end
  endgenerate

endmodule

// File: rtl/lfsr_pattern_gen.sv
// Valid/ready LFSR pattern source with seed load, lockup rejection and beat counter.
// Optional LFSR_PERIOD_CHECK_EN adds period_done, pulsed when the sequence returns to its start state.
module lfsr_pattern_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH          = 64,
  parameter logic [63:0]      POLY           = LFSR_POLY_64,
  parameter int unsigned      MODE           = 0,
  parameter int unsigned      STEPS_PER_BEAT = 1,
  parameter logic [WIDTH-1:0] SEED           = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             en,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             lockup,
  output logic [31:0]      beat_count
`ifdef LFSR_PERIOD_CHECK_EN
  ,
  output logic             period_done
`endif
);

  localparam bit               GALOIS   = (MODE == 32'(LFSR_GAL_XOR));
  localparam logic [WIDTH-1:0] LOCK_VAL = GALOIS ? {WIDTH{1'b0}} : {WIDTH{1'b1}};

  fsm_state_t       state_q, state_nxt;
  logic [WIDTH-1:0] lfsr_q, lfsr_nxt;
  logic [WIDTH-1:0] beat_c;
  logic [31:0]      count_nxt;
  logic             lockup_nxt;
  logic             valid_nxt;
  logic             hs_c;
  logic             seed_bad_c;

  // Unrolled chain of single steps forming one beat
  logic [WIDTH-1:0] chain [STEPS_PER_BEAT+1];
  assign chain[0] = lfsr_q;
  for (genvar i = 0; i < STEPS_PER_BEAT; i++) begin : g_chain
    lfsr_step #(.WIDTH(WIDTH), .POLY(POLY), .MODE(MODE)) u_step (
      .cur(chain[i]),
      .nxt(chain[i+1])
    );
  end
  assign beat_c = chain[STEPS_PER_BEAT];

  assign out_data   = lfsr_q;
  assign hs_c       = out_valid && out_ready;
  assign seed_bad_c = (seed == LOCK_VAL);

`ifdef LFSR_PERIOD_CHECK_EN
  logic [WIDTH-1:0] start_q, start_nxt;
  logic             period_nxt;
`endif

  // Next-state: seed_load overrides everything, including a same-cycle handshake
  always_comb begin
    state_nxt  = state_q;
    lfsr_nxt   = lfsr_q;
    count_nxt  = beat_count;
    lockup_nxt = lockup;
`ifdef LFSR_PERIOD_CHECK_EN
    start_nxt  = start_q;
    period_nxt = 1'b0;
`endif
    if (seed_load) begin
      state_nxt  = IDLE;
      lfsr_nxt   = seed_bad_c ? SEED : seed;
      count_nxt  = 32'd0;
      lockup_nxt = lockup | seed_bad_c;
`ifdef LFSR_PERIOD_CHECK_EN
      start_nxt  = seed_bad_c ? SEED : seed;
`endif
    end else begin
      case (state_q)
        IDLE: if (en) state_nxt = RUN;
        RUN: begin
          if (hs_c) begin
            lfsr_nxt  = beat_c;
            count_nxt = beat_count + 32'd1;
`ifdef LFSR_PERIOD_CHECK_EN
            period_nxt = (beat_c == start_q);
`endif
          end
          if (!en) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
    valid_nxt = (state_nxt == RUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      lfsr_q     <= SEED;
      out_valid  <= 1'b0;
      lockup     <= 1'b0;
      beat_count <= 32'd0;
    end else begin
      state_q    <= state_nxt;
      lfsr_q     <= lfsr_nxt;
      out_valid  <= valid_nxt;
      lockup     <= lockup_nxt;
      beat_count <= count_nxt;
    end
  end

`ifdef LFSR_PERIOD_CHECK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_q     <= SEED;
      period_done <= 1'b0;
    end else begin
      start_q     <= start_nxt;
      period_done <= period_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_pattern_gen.sv
// Directed bench for lfsr_pattern_gen: 8-bit Fibonacci, Galois and 8-steps-per-beat instances.
module tb_lfsr_pattern_gen;
  import lfsr_pkg::*;

  logic       clk;
  logic       reset_n;
  logic       seed_load;
  logic       en;
  logic       out_ready;
  logic [7:0] sf, sg, ss;

  logic        vf, vg, vs;
  logic [7:0]  df, dg, ds;
  logic        lf, lg, ls;
  logic [31:0] cf, cg, cs;
`ifdef LFSR_PERIOD_CHECK_EN
  logic pf, pg, ps;
`endif

  int errors = 0;
  int checks = 0;

  lfsr_pattern_gen #(.WIDTH(8), .POLY(64'(LFSR_POLY_8)), .MODE(0), .STEPS_PER_BEAT(1), .SEED(8'h01)) u_fib (
    .clk(clk), .reset_n(reset_n), .seed_load(seed_load), .seed(sf), .en(en), .out_ready(out_ready),
    .out_valid(vf), .out_data(df), .lockup(lf), .beat_count(cf)
`ifdef LFSR_PERIOD_CHECK_EN
    , .period_done(pf)
`endif
  );

  lfsr_pattern_gen #(.WIDTH(8), .POLY(64'(LFSR_POLY_8)), .MODE(1), .STEPS_PER_BEAT(1), .SEED(8'h01)) u_gal (
    .clk(clk), .reset_n(reset_n), .seed_load(seed_load), .seed(sg), .en(en), .out_ready(out_ready),
    .out_valid(vg), .out_data(dg), .lockup(lg), .beat_count(cg)
`ifdef LFSR_PERIOD_CHECK_EN
    , .period_done(pg)
`endif
  );

  lfsr_pattern_gen #(.WIDTH(8), .POLY(64'(LFSR_POLY_8)), .MODE(0), .STEPS_PER_BEAT(8), .SEED(8'h01)) u_stp (
    .clk(clk), .reset_n(reset_n), .seed_load(seed_load), .seed(ss), .en(en), .out_ready(out_ready),
    .out_valid(vs), .out_data(ds), .lockup(ls), .beat_count(cs)
`ifdef LFSR_PERIOD_CHECK_EN
    , .period_done(ps)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_f [6] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E};
  logic [7:0] exp_g [6] = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
  logic [7:0] exp_s [3] = '{8'h00, 8'hF4, 8'h39};

  initial begin
    reset_n = 1'b1; seed_load = 1'b0; en = 1'b0; out_ready = 1'b0;
    sf = 8'h00; sg = 8'h00; ss = 8'h00;
    #1 reset_n = 1'b0;
    #2;
    check("rst_valid", 32'(vf), 32'd0);
    check("rst_data", 32'(df), 32'h01);
    check("rst_lockup", 32'(lf), 32'd0);
    check("rst_count", cf, 32'd0);
    #9 reset_n = 1'b1;

    // Load seeds, then start running with the consumer always ready
    sf = 8'h00; sg = 8'h01; ss = 8'h00; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    check("load_data_f", 32'(df), 32'h00);
    check("load_data_g", 32'(dg), 32'h01);
    check("load_valid", 32'(vf), 32'd0);
    en = 1'b1; out_ready = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) begin
      check($sformatf("fib_seq%0d", k), 32'(df), 32'(exp_f[k]));
      check($sformatf("gal_seq%0d", k), 32'(dg), 32'(exp_g[k]));
      check($sformatf("valid%0d", k), 32'(vf), 32'd1);
      if (k < 3) check($sformatf("step8_seq%0d", k), 32'(ds), 32'(exp_s[k]));
      tick();
    end
    check("fib_count6", cf, 32'd6);
    check("fib_next", 32'(df), 32'h3D);

    // Backpressure holds the beat steady
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("bp_valid%0d", k), 32'(vf), 32'd1);
      check($sformatf("bp_data%0d", k), 32'(df), 32'h3D);
      check($sformatf("bp_count%0d", k), cf, 32'd6);
    end
    out_ready = 1'b1;
    tick();
    check("bp_resume", 32'(df), 32'h7A);
    check("bp_count7", cf, 32'd7);

    // en drop with a handshake completes the beat, then idles
    en = 1'b0;
    tick();
    check("endrop_data", 32'(df), 32'hF4);
    check("endrop_count", cf, 32'd8);
    check("endrop_valid", 32'(vf), 32'd0);
    tick();
    check("idle_hold", 32'(df), 32'hF4);

    // Seed load beats a same-cycle handshake; lockup seed is replaced with SEED
    en = 1'b1;
    tick();
    check("rerun_valid", 32'(vf), 32'd1);
    sf = 8'hFF; seed_load = 1'b1;
    tick();
    check("lock_data", 32'(df), 32'h01);
    check("lock_flag", 32'(lf), 32'd1);
    check("lock_count", cf, 32'd0);
    check("lock_valid", 32'(vf), 32'd0);
    sf = 8'h00;
    tick();
    seed_load = 1'b0;
    check("lock_sticky", 32'(lf), 32'd1);
    check("lock_reload", 32'(df), 32'h00);
    tick();
    tick();
    tick();
    check("pre_rst_data", 32'(df), 32'h03);

    // Asynchronous reset takes effect between clock edges
    #1 reset_n = 1'b0;
    #1;
    check("arst_valid", 32'(vf), 32'd0);
    check("arst_data", 32'(df), 32'h01);
    check("arst_count", cf, 32'd0);
    check("arst_lockup", 32'(lf), 32'd0);
    #1 reset_n = 1'b1;

`ifdef LFSR_PERIOD_CHECK_EN
    sf = 8'h00; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    check("pd_idle", 32'(pf), 32'd0);
    tick();
    for (int n = 1; n <= 520; n++) begin
      tick();
      check($sformatf("period_n%0d", n), 32'(pf), 32'((n == 255) || (n == 510)));
    end
    check("pd_count", cf, 32'd520);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
